// File: rtl/snes_controller_responder.sv
// SNES gamepad emulator: answers a host's LATCH/PULSE handshake by serialising
// a 12-button word plus the 4-bit pad ID onto DATA (active-low on the wire).
module snes_controller_responder #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic        LATCH,
    input  logic        PULSE,
    input  logic [11:0] BUTTONS,
    output logic        DATA,
    output logic [4:0]  BIT_INDEX,
    output logic        FRAME_DONE
);

    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic logic [15:0] frame_word(input logic [11:0] buttons);
        return {4'hF, ~buttons};
    endfunction

    logic [SYNC_STAGES-1:0] latch_sync_p0, pulse_sync_p0;
    logic                   latch_filt_p1, pulse_filt_p1;
    logic [FW-1:0]          latch_cnt, pulse_cnt;
    logic                   pulse_prev_p2;
    logic                   latch_in, pulse_in, pulse_rise;

    logic [1:0]    state;
    logic [15:0]   sreg;
    logic [4:0]    bit_idx;
    logic          data_q, frame_done_q;
    logic [TW-1:0] timeout;

    assign latch_in   = latch_sync_p0[SYNC_STAGES-1];
    assign pulse_in   = pulse_sync_p0[SYNC_STAGES-1];
    assign pulse_rise = pulse_filt_p1 & ~pulse_prev_p2;

    // Stage p0: synchronisers, preset to the idle bus levels so reset release is edge-free
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            latch_sync_p0 <= '0;
            pulse_sync_p0 <= '1;
        end else begin
            latch_sync_p0 <= {latch_sync_p0[SYNC_STAGES-2:0], LATCH};
            pulse_sync_p0 <= {pulse_sync_p0[SYNC_STAGES-2:0], PULSE};
        end
    end

    // Stage p1: a level only flips after FILTER_CYCLES consecutive disagreeing samples
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            latch_filt_p1 <= 1'b0;
            pulse_filt_p1 <= 1'b1;
            latch_cnt     <= '0;
            pulse_cnt     <= '0;
        end else begin
            if (latch_in == latch_filt_p1) begin
                latch_cnt <= '0;
            end else if (latch_cnt == FILT_LAST) begin
                latch_filt_p1 <= latch_in;
                latch_cnt     <= '0;
            end else begin
                latch_cnt <= latch_cnt + FW'(1);
            end

            if (pulse_in == pulse_filt_p1) begin
                pulse_cnt <= '0;
            end else if (pulse_cnt == FILT_LAST) begin
                pulse_filt_p1 <= pulse_in;
                pulse_cnt     <= '0;
            end else begin
                pulse_cnt <= pulse_cnt + FW'(1);
            end
        end
    end

    // Stage p2: edge history and frame FSM
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            pulse_prev_p2 <= 1'b1;
            state         <= ST_IDLE;
            sreg          <= '1;
            bit_idx       <= '0;
            data_q        <= 1'b1;
            frame_done_q  <= 1'b0;
            timeout       <= '0;
        end else begin
            pulse_prev_p2 <= pulse_filt_p1;
            frame_done_q  <= 1'b0;
            // A high latch restarts the frame from any state; edges in LOAD are ignored
            if (latch_filt_p1) begin
                state   <= ST_LOAD;
                sreg    <= frame_word(BUTTONS);
                data_q  <= ~BUTTONS[0];
                bit_idx <= '0;
                timeout <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        data_q  <= 1'b1;
                        bit_idx <= '0;
                    end
                    ST_LOAD: begin
                        state  <= ST_SHIFT;
                        data_q <= sreg[0];
                    end
                    ST_SHIFT: begin
                        if (pulse_rise) begin
                            sreg    <= {1'b1, sreg[15:1]};
                            data_q  <= sreg[1];
                            bit_idx <= bit_idx + 5'd1;
                            timeout <= '0;
                            if (bit_idx == 5'd15) begin
                                state        <= ST_DONE;
                                frame_done_q <= 1'b1;
                                data_q       <= 1'b1;
                            end
                        end else if (timeout == TO_LAST) begin
                            state   <= ST_IDLE;
                            bit_idx <= '0;
                            data_q  <= 1'b1;
                            timeout <= '0;
                        end else begin
                            timeout <= timeout + TW'(1);
                        end
                    end
                    ST_DONE: begin
                        data_q  <= 1'b1;
                        bit_idx <= 5'd16;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign DATA       = data_q;
    assign BIT_INDEX  = bit_idx;
    assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_snes_controller_responder.sv
// Bench for snes_controller_responder: a host driver issues LATCH/PULSE traffic and
// queues expected pad outputs from a frame model; a monitor pops and compares them.
module tb_snes_controller_responder;

    localparam int TO = 400;

    logic        CLOCK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        LATCH = 1'b0;
    logic        PULSE = 1'b1;
    logic [11:0] BUTTONS = '0;
    logic        DATA;
    logic [4:0]  BIT_INDEX;
    logic        FRAME_DONE;

    snes_controller_responder #(
        .SYNC_STAGES   (2),
        .FILTER_CYCLES (4),
        .TIMEOUT_CYCLES(TO)
    ) u_dut (
        .CLOCK     (CLOCK),
        .RESET_N   (RESET_N),
        .LATCH     (LATCH),
        .PULSE     (PULSE),
        .BUTTONS   (BUTTONS),
        .DATA      (DATA),
        .BIT_INDEX (BIT_INDEX),
        .FRAME_DONE(FRAME_DONE)
    );

    always #10 CLOCK = ~CLOCK;

    typedef struct {
        string name;
        logic  data;
        int    idx;
    } exp_t;

    exp_t sb_q[$];
    int   fd_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail = 0;
    logic probe = 1'b0;
    logic fd_prev = 1'b0;
    int   hp = 12;

    // Frame model: the word captured at latch fall and the number of counted pulses
    logic [11:0] m_btn = '0;
    int          m_cnt = 0;

    function automatic logic exp_data();
        if (m_cnt >= 12) return 1'b1;
        return ~m_btn[m_cnt];
    endfunction

    function automatic int exp_idx();
        return (m_cnt > 16) ? 16 : m_cnt;
    endfunction

    // Monitor
    always @(negedge CLOCK) begin
        if (probe) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard: probe with no expected entry");
            end else begin
                e = sb_q.pop_front();
                if (DATA !== e.data || BIT_INDEX !== 5'(e.idx)) begin
                    n_fail++;
                    $display("FAIL %s: DATA=%0b BIT_INDEX=%0d, required DATA=%0b BIT_INDEX=%0d",
                             e.name, DATA, BIT_INDEX, e.data, e.idx);
                end
            end
        end
        if (FRAME_DONE !== 1'b0) begin
            n_checks++;
            if (fd_q.size() == 0 || fd_prev) begin
                n_fail++;
                $display("FAIL frame_done: FRAME_DONE=%0b (prev %0b), required 0", FRAME_DONE, fd_prev);
            end else begin
                void'(fd_q.pop_front());
            end
        end
        fd_prev = FRAME_DONE;
    end

    initial begin
        #(20 * 90000);
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLOCK);
            #2;
        end
    endtask

    task automatic expect_out(input string name, input logic d, input int idx);
        sb_q.push_back('{name, d, idx});
        probe = 1'b1;
        tick(1);
        probe = 1'b0;
    endtask

    task automatic check_fd(input string name);
        n_checks++;
        if (fd_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: FRAME_DONE pulses still pending=%0d, required 0", name, fd_q.size());
            fd_q.delete();
        end
    endtask

    task automatic do_latch(input logic [11:0] b);
        BUTTONS = b;
        LATCH = 1'b1;
        tick(hp);
        expect_out("load_data", ~b[0], 0);
        LATCH = 1'b0;
        tick(hp);
        m_btn = b;
        m_cnt = 0;
        BUTTONS = 12'($urandom);
        expect_out("bit0_after_latch", exp_data(), 0);
    endtask

    task automatic host_pulse();
        PULSE = 1'b0;
        tick(hp);
        expect_out($sformatf("sample_bit%0d", m_cnt), exp_data(), exp_idx());
        if (m_cnt == 15) fd_q.push_back(1);
        PULSE = 1'b1;
        m_cnt++;
        tick(hp);
    endtask

    task automatic full_frame(input logic [11:0] b);
        do_latch(b);
        repeat (16) host_pulse();
        tick(hp);
        check_fd("frame_done_seen");
    endtask

    logic [11:0] b;

    initial begin
        // Reset and release at idle levels
        tick(5);
        expect_out("reset_hold", 1'b1, 0);
        RESET_N = 1'b1;
        tick(20);
        expect_out("reset_release", 1'b1, 0);

        // Known frame, then reads past the end saturate
        hp = 12;
        full_frame(12'h0A5);
        host_pulse();
        host_pulse();
        expect_out("done_saturate", 1'b1, 16);

        // Randomised frames and host speeds
        repeat (3) begin
            hp = $urandom_range(10, 20);
            full_frame(12'($urandom));
        end

        // Live load with a pulse during latch, buttons changed after latch fall
        hp = 12;
        BUTTONS = 12'h000;
        LATCH = 1'b1;
        tick(hp);
        expect_out("live_load_000", 1'b1, 0);
        BUTTONS = 12'hFFF;
        tick(hp);
        expect_out("live_load_fff", 1'b0, 0);
        PULSE = 1'b0;
        tick(hp);
        PULSE = 1'b1;
        tick(hp);
        expect_out("pulse_in_load", 1'b0, 0);
        LATCH = 1'b0;
        tick(hp);
        m_btn = 12'hFFF;
        m_cnt = 0;
        BUTTONS = 12'h001;
        repeat (16) host_pulse();
        tick(hp);
        check_fd("live_load_frame_done");

        // Glitch rejection on PULSE
        do_latch(12'($urandom));
        repeat (3) host_pulse();
        repeat (2) begin
            PULSE = 1'b0;
            tick(2);
            PULSE = 1'b1;
            tick(hp);
            expect_out("glitch2", exp_data(), exp_idx());
        end
        PULSE = 1'b0;
        tick(3);
        PULSE = 1'b1;
        tick(hp);
        expect_out("glitch3", exp_data(), exp_idx());
        PULSE = 1'b0;
        tick(10);
        PULSE = 1'b1;
        m_cnt++;
        tick(hp);
        expect_out("pulse10", exp_data(), exp_idx());

        // Relatch mid-frame: response lands exactly on the 7th cycle
        host_pulse();
        b = 12'($urandom);
        BUTTONS = b;
        LATCH = 1'b1;
        tick(6);
        expect_out("relatch_cycle6", exp_data(), exp_idx());
        expect_out("relatch_cycle7", ~b[0], 0);
        tick(hp);
        LATCH = 1'b0;
        tick(hp);
        m_btn = b;
        m_cnt = 0;
        repeat (16) host_pulse();
        tick(hp);
        check_fd("relatch_frame_done");

        // PULSE rising together with LATCH: latch wins
        do_latch(12'($urandom));
        repeat (4) host_pulse();
        PULSE = 1'b0;
        tick(hp);
        b = 12'($urandom);
        BUTTONS = b;
        LATCH = 1'b1;
        PULSE = 1'b1;
        tick(hp);
        expect_out("latch_wins", ~b[0], 0);
        LATCH = 1'b0;
        tick(hp);
        m_btn = b;
        m_cnt = 0;
        expect_out("latch_wins_bit0", exp_data(), 0);
        repeat (16) host_pulse();
        tick(hp);
        check_fd("latch_wins_frame_done");

        // Timeout abandons a partial frame without FRAME_DONE
        do_latch(12'($urandom));
        repeat (3) host_pulse();
        tick(TO - 100);
        expect_out("pre_timeout", exp_data(), 3);
        tick(200);
        expect_out("timeout_idle", 1'b1, 0);
        PULSE = 1'b0;
        tick(hp);
        PULSE = 1'b1;
        tick(hp);
        expect_out("pulse_in_idle", 1'b1, 0);

        // Reset mid-frame
        do_latch(12'($urandom));
        repeat (6) host_pulse();
        RESET_N = 1'b0;
        expect_out("reset_mid_frame", 1'b1, 0);
        tick(3);
        RESET_N = 1'b1;
        tick(20);
        expect_out("reset_mid_release", 1'b1, 0);
        full_frame(12'($urandom));

        tick(20);
        n_checks++;
        if (sb_q.size() != 0 || fd_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: scoreboard=%0d frame_done=%0d left, required 0", sb_q.size(), fd_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
